// File: rtl/regfile_arb_pkg.sv
// Shared constants and types for the register-file write arbiter.
// Register targets, grant source encoding and the buffered write entry.
package regfile_arb_pkg;

    localparam logic [4:0] K0_ADDR        = 5'd26;
    localparam logic [4:0] UART_REG1_ADDR = 5'd24;
    localparam logic [4:0] UART_REG2_ADDR = 5'd25;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_WB   = 2'd1,
        SRC_TRAP = 2'd2,
        SRC_UART = 2'd3
    } arb_src_e;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } rf_wr_t;

    // $0 never creates a hazard, so a zero source never matches.
    function automatic logic src_hit(input logic [4:0] src, input logic [4:0] addr);
        return (src != 5'd0) && (src == addr);
    endfunction

endpackage

// File: rtl/rf_arb_fifo.sv
// Circular write buffer for UART register writes; exposes per-entry
// valid/address so the arbiter can compare every pending target with ID sources.
module rf_arb_fifo
    import regfile_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  rf_wr_t                       push_entry,
    input  logic                         pop,
    output rf_wr_t                       head,
    output logic [$clog2(DEPTH):0]       count,
    output logic [DEPTH-1:0]             entry_valid,
    output logic [DEPTH-1:0][4:0]        entry_addr
);

    localparam int unsigned PW = $clog2(DEPTH);

    rf_wr_t        mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset)
            mem[wr_ptr] <= push_entry;
    end

    assign head = mem[rd_ptr];

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        entry_valid = '0;
        entry_addr  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_valid[i] = {1'b0, PW'(i) - rd_ptr} < count;
            entry_addr[i]  = mem[i].addr;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Single write port arbiter for the ID-stage register file: WB, buffered
// trap ($k0) and UART writes, with anti-starvation hold and ID read hazard stall.
module regfile_write_arbiter #(
    parameter int unsigned UART_FIFO_DEPTH = 4,
    parameter int unsigned STARVE_LIMIT    = 8,
    parameter logic [4:0]  K0_ADDR         = regfile_arb_pkg::K0_ADDR,
    parameter logic [4:0]  UART_REG1_ADDR  = regfile_arb_pkg::UART_REG1_ADDR,
    parameter logic [4:0]  UART_REG2_ADDR  = regfile_arb_pkg::UART_REG2_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        trap_req,
    input  logic [31:0] trap_data,
    output logic        trap_busy,
    output logic        trap_ack,
    input  logic        uart_valid,
    input  logic        uart_flag,
    input  logic [7:0]  uart_data,
    output logic        uart_ready,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    output logic        hazard_stall,
    output logic        pipe_hold,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data
);

    import regfile_arb_pkg::*;

    localparam int unsigned CW = $clog2(UART_FIFO_DEPTH) + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FIFO_FULL  = CW'(UART_FIFO_DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic                             trap_valid;
    logic [31:0]                      trap_q;
    logic                             trap_capture;
    logic [SW-1:0]                    starve_cnt;
    logic [SW-1:0]                    starve_next;
    logic                             pipe_hold_q;
    logic                             pending;
    logic                             buf_grant;
    arb_src_e                         src;

    logic                             fifo_push;
    logic                             fifo_pop;
    logic                             fifo_nonempty;
    rf_wr_t                           uart_entry;
    rf_wr_t                           fifo_head;
    logic [CW-1:0]                    fifo_count;
    logic [UART_FIFO_DEPTH-1:0]       fifo_valid;
    logic [UART_FIFO_DEPTH-1:0][4:0]  fifo_addr;

    assign uart_entry.addr = uart_flag ? UART_REG2_ADDR : UART_REG1_ADDR;
    assign uart_entry.data = {24'h0, uart_data};

    assign uart_ready    = !reset && (fifo_count != FIFO_FULL);
    assign fifo_push     = uart_valid && uart_ready;
    assign fifo_pop      = (src == SRC_UART);
    assign fifo_nonempty = (fifo_count != '0);

    rf_arb_fifo #(
        .DEPTH(UART_FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_push),
        .push_entry (uart_entry),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .count      (fifo_count),
        .entry_valid(fifo_valid),
        .entry_addr (fifo_addr)
    );

    // WB to $0 is dropped so the slot falls through to the buffered sources.
    always_comb begin
        src = SRC_NONE;
        if (reset)
            src = SRC_NONE;
        else if (wb_we && (wb_addr != '0) && !pipe_hold_q)
            src = SRC_WB;
        else if (trap_valid)
            src = SRC_TRAP;
        else if (fifo_nonempty)
            src = SRC_UART;
    end

    always_comb begin
        rf_we   = 1'b0;
        rf_addr = '0;
        rf_data = '0;
        case (src)
            SRC_WB:   begin rf_we = 1'b1; rf_addr = wb_addr;        rf_data = wb_data;        end
            SRC_TRAP: begin rf_we = 1'b1; rf_addr = K0_ADDR;        rf_data = trap_q;         end
            SRC_UART: begin rf_we = 1'b1; rf_addr = fifo_head.addr; rf_data = fifo_head.data; end
            default:  ;
        endcase
    end

    assign trap_ack  = (src == SRC_TRAP);
    assign trap_busy = !reset && trap_valid;
    assign pipe_hold = !reset && pipe_hold_q;

    // A new trap may land in the same cycle the old one drains.
    assign trap_capture = trap_req && (!trap_valid || (src == SRC_TRAP));

    always_ff @(posedge clk) begin
        if (reset) begin
            trap_valid <= 1'b0;
            trap_q     <= '0;
        end else if (trap_capture) begin
            trap_valid <= 1'b1;
            trap_q     <= trap_data;
        end else if (src == SRC_TRAP) begin
            trap_valid <= 1'b0;
        end
    end

    assign pending   = trap_valid || fifo_nonempty;
    assign buf_grant = (src == SRC_TRAP) || (src == SRC_UART);

    always_comb begin
        starve_next = starve_cnt;
        if (!pending || buf_grant)
            starve_next = '0;
        else if (starve_cnt != STARVE_MAX)
            starve_next = starve_cnt + 1'b1;
    end

    // The hold cycle always grants a buffered source, which clears the counter,
    // so pipe_hold is a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt  <= '0;
            pipe_hold_q <= 1'b0;
        end else begin
            starve_cnt  <= starve_next;
            pipe_hold_q <= (starve_next == STARVE_MAX);
        end
    end

    always_comb begin
        hazard_stall = 1'b0;
        if (trap_valid && (src_hit(id_rs, K0_ADDR) || src_hit(id_rt, K0_ADDR)))
            hazard_stall = 1'b1;
        for (int unsigned i = 0; i < UART_FIFO_DEPTH; i++) begin
            if (fifo_valid[i] && (src_hit(id_rs, fifo_addr[i]) || src_hit(id_rt, fifo_addr[i])))
                hazard_stall = 1'b1;
        end
        if (reset)
            hazard_stall = 1'b0;
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: expected writes are queued as
// stimulus is driven and compared as the write port retires them.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        trap_req;
    logic [31:0] trap_data;
    logic        trap_busy;
    logic        trap_ack;
    logic        uart_valid;
    logic        uart_flag;
    logic [7:0]  uart_data;
    logic        uart_ready;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        hazard_stall;
    logic        pipe_hold;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;

    int          n_chk = 0;
    int          n_err = 0;
    logic [36:0] wb_q  [$];
    logic [36:0] buf_q [$];
    logic [36:0] mon_e;
    logic        exp_hold;
    int          ub_idx;
    logic [7:0]  ub [5] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .UART_FIFO_DEPTH(4),
        .STARVE_LIMIT   (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .trap_req    (trap_req),
        .trap_data   (trap_data),
        .trap_busy   (trap_busy),
        .trap_ack    (trap_ack),
        .uart_valid  (uart_valid),
        .uart_flag   (uart_flag),
        .uart_data   (uart_data),
        .uart_ready  (uart_ready),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .hazard_stall(hazard_stall),
        .pipe_hold   (pipe_hold),
        .rf_we       (rf_we),
        .rf_addr     (rf_addr),
        .rf_data     (rf_data)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Buffered targets (24/25/26) retire in their own order; WB writes in theirs.
    always @(negedge clk) begin
        if (rf_we) begin
            if (rf_addr inside {5'd24, 5'd25, 5'd26}) begin
                if (buf_q.size() == 0) begin
                    check_eq("unexpected_buf_wr", 32'(rf_addr), 32'd0);
                end else begin
                    mon_e = buf_q.pop_front();
                    check_eq("buf_addr", 32'(rf_addr), 32'(mon_e[36:32]));
                    check_eq("buf_data", rf_data, mon_e[31:0]);
                end
            end else begin
                if (wb_q.size() == 0) begin
                    check_eq("unexpected_wb_wr", 32'(rf_addr), 32'd0);
                end else begin
                    mon_e = wb_q.pop_front();
                    check_eq("wb_addr", 32'(rf_addr), 32'(mon_e[36:32]));
                    check_eq("wb_data", rf_data, mon_e[31:0]);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        trap_req = 1'b0; trap_data = '0; uart_valid = 1'b0; uart_flag = 1'b0;
        uart_data = '0; id_rs = '0; id_rt = '0;
        step; step;
        #2;
        check_eq("rst_rf_we",      32'(rf_we),      32'd0);
        check_eq("rst_uart_ready", 32'(uart_ready), 32'd0);
        check_eq("rst_trap_busy",  32'(trap_busy),  32'd0);
        check_eq("rst_pipe_hold",  32'(pipe_hold),  32'd0);
        reset = 1'b0;
        #2;
        check_eq("post_rst_ready", 32'(uart_ready), 32'd1);
        step;

        // Single trap write
        trap_req = 1'b1; trap_data = 32'h0040_0010;
        buf_q.push_back({5'd26, 32'h0040_0010});
        #2;
        check_eq("trapA_busy0", 32'(trap_busy), 32'd0);
        check_eq("trapA_no_wr", 32'(rf_we),     32'd0);
        step;
        trap_req = 1'b0; id_rs = 5'd26;
        #2;
        check_eq("trapA_we",     32'(rf_we),        32'd1);
        check_eq("trapA_addr",   32'(rf_addr),      32'd26);
        check_eq("trapA_data",   rf_data,           32'h0040_0010);
        check_eq("trapA_ack",    32'(trap_ack),     32'd1);
        check_eq("trapA_hazard", 32'(hazard_stall), 32'd1);
        step;
        #2;
        check_eq("trapA_busy_clr", 32'(trap_busy),    32'd0);
        check_eq("trapA_ack_clr",  32'(trap_ack),     32'd0);
        check_eq("trapA_haz_clr",  32'(hazard_stall), 32'd0);
        id_rs = '0;
        step;

        // Back-to-back traps: new one captured while old one is written
        trap_req = 1'b1; trap_data = 32'h1111_0001;
        buf_q.push_back({5'd26, 32'h1111_0001});
        buf_q.push_back({5'd26, 32'h2222_0002});
        step;
        trap_data = 32'h2222_0002;
        #2;
        check_eq("trapF_ack1",  32'(trap_ack), 32'd1);
        check_eq("trapF_data1", rf_data,       32'h1111_0001);
        step;
        trap_req = 1'b0;
        #2;
        check_eq("trapF_ack2",  32'(trap_ack), 32'd1);
        check_eq("trapF_data2", rf_data,       32'h2222_0002);
        step;
        #2;
        check_eq("trapF_busy_clr", 32'(trap_busy), 32'd0);
        step;

        // WB beats a pending trap; $k0 follows next cycle
        trap_req = 1'b1; trap_data = 32'hDEAD_0001;
        buf_q.push_back({5'd26, 32'hDEAD_0001});
        step;
        trap_req = 1'b0; wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'h1111_2222;
        wb_q.push_back({5'd8, 32'h1111_2222});
        #2;
        check_eq("wbB_addr", 32'(rf_addr),   32'd8);
        check_eq("wbB_ack0", 32'(trap_ack),  32'd0);
        check_eq("wbB_busy", 32'(trap_busy), 32'd1);
        step;
        wb_we = 1'b0;
        #2;
        check_eq("wbB_k0_addr", 32'(rf_addr),  32'd26);
        check_eq("wbB_k0_ack",  32'(trap_ack), 32'd1);
        step;

        // UART entry to 25 with id_rt hazard; WB to $0 frees the port
        uart_valid = 1'b1; uart_flag = 1'b1; uart_data = 8'h5A; id_rt = 5'd25;
        wb_q.push_back({5'd9, 32'h0000_0099});
        buf_q.push_back({5'd25, 32'h0000_005A});
        #2;
        check_eq("uC_ready",     32'(uart_ready),   32'd1);
        check_eq("uC_haz_empty", 32'(hazard_stall), 32'd0);
        step;
        uart_valid = 1'b0; wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_0099;
        #2;
        check_eq("uC_wb_first", 32'(rf_addr),      32'd9);
        check_eq("uC_haz_pend", 32'(hazard_stall), 32'd1);
        id_rt = '0;
        #1;
        check_eq("uC_haz_rt0",  32'(hazard_stall), 32'd0);
        id_rt = 5'd25;
        step;
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        #2;
        check_eq("uC_wb0_we",   32'(rf_we),        32'd1);
        check_eq("uC_wb0_addr", 32'(rf_addr),      32'd25);
        check_eq("uC_wb0_data", rf_data,           32'h0000_005A);
        check_eq("uC_haz_wr",   32'(hazard_stall), 32'd1);
        step;
        wb_we = 1'b0;
        #2;
        check_eq("uC_haz_done", 32'(hazard_stall), 32'd0);
        check_eq("uC_idle",     32'(rf_we),        32'd0);
        id_rt = '0;
        step;

        // Push and pop in the same cycle keeps the count
        uart_valid = 1'b1; uart_flag = 1'b0; uart_data = 8'h11;
        buf_q.push_back({5'd24, 32'h0000_0011});
        step;
        uart_flag = 1'b1; uart_data = 8'h22;
        buf_q.push_back({5'd25, 32'h0000_0022});
        #2;
        check_eq("uG_pop_addr", 32'(rf_addr),    32'd24);
        check_eq("uG_ready",    32'(uart_ready), 32'd1);
        step;
        uart_valid = 1'b0;
        #2;
        check_eq("uG_pop2_data", rf_data, 32'h0000_0022);
        step;
        #2;
        check_eq("uG_empty", 32'(rf_we), 32'd0);
        step;

        // Five bytes against a continuously writing WB stage
        ub_idx = 0;
        for (int k = 0; k < 48; k++) begin
            exp_hold = (k >= 9) && (((k - 9) % 9) == 0);
            wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'h1000 + 32'(k);
            if (!exp_hold)
                wb_q.push_back({5'd8, 32'h1000 + 32'(k)});
            if (ub_idx < 5) begin
                uart_valid = 1'b1; uart_flag = 1'b0; uart_data = ub[ub_idx];
            end else begin
                uart_valid = 1'b0;
            end
            #2;
            check_eq("uD_hold", 32'(pipe_hold), 32'(exp_hold));
            if (k <= 10)
                check_eq("uD_ready", 32'(uart_ready), 32'((k < 4) || (k == 10)));
            if (ub_idx < 5 && uart_ready) begin
                buf_q.push_back({5'd24, 24'h0, ub[ub_idx]});
                ub_idx++;
            end
            step;
        end
        wb_we = 1'b0; uart_valid = 1'b0;
        step;

        // Reset mid-run with three FIFO entries and a trap pending
        wb_we = 1'b1; wb_addr = 5'd8; uart_flag = 1'b0;
        for (int m = 0; m < 3; m++) begin
            wb_data = 32'h2000 + 32'(m);
            wb_q.push_back({5'd8, 32'h2000 + 32'(m)});
            uart_valid = 1'b1; uart_data = 8'h30 + 8'(m);
            trap_req = (m == 0); trap_data = 32'h0000_BAD0;
            step;
        end
        uart_valid = 1'b0; trap_req = 1'b0; wb_we = 1'b0; id_rs = 5'd26;
        #2;
        check_eq("rE_busy_pre", 32'(trap_busy), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("rE_rf_we",  32'(rf_we),        32'd0);
        check_eq("rE_ready0", 32'(uart_ready),   32'd0);
        check_eq("rE_busy0",  32'(trap_busy),    32'd0);
        check_eq("rE_haz0",   32'(hazard_stall), 32'd0);
        step;
        reset = 1'b0;
        #2;
        check_eq("rE_post_we",    32'(rf_we),        32'd0);
        check_eq("rE_post_ready", 32'(uart_ready),   32'd1);
        check_eq("rE_post_busy",  32'(trap_busy),    32'd0);
        check_eq("rE_post_haz",   32'(hazard_stall), 32'd0);
        step;
        #2;
        check_eq("rE_still_idle", 32'(rf_we), 32'd0);
        id_rs = '0;
        step; step;

        check_eq("wb_q_left",  32'(wb_q.size()),  32'd0);
        check_eq("buf_q_left", 32'(buf_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
